// File: rtl/alu_step_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_step_ctrl_pkg
// Shared constants for the ALU step sequencer and anything that decodes its
// step output (LED display). Holds the state codes, the step width and the
// width of the S_EXEC wait counter.
// -----------------------------------------------------------------------------
package alu_step_ctrl_pkg;

  localparam int STEP_W = 3;
  localparam int WAIT_W = 4;   // covers EXEC_WAIT-1 for EXEC_WAIT up to 15
  localparam int OP_W   = 4;

  // Codes 5..7 are never targeted; the FSM maps them back to S_A.
  typedef enum logic [STEP_W-1:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } step_e;

endpackage

// File: rtl/alu_step_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw pushbutton: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on an accepted 0->1 transition (releases are silent).
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   raw   : unsynchronized button level, active-high
//   press : registered one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronized level disagrees with the
  // accepted one; any return to agreement restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_step_ctrl.sv
// -----------------------------------------------------------------------------
// alu_step_ctrl
// Step sequencer for the operand / ALU / flag datapath. Two debounced buttons
// walk the FSM through load A, load B, opcode capture, ALU settle and result
// strobe.
//   clk      : system clock            rst_n : async active-low reset
//   btn_step : raw step button         btn_clr : raw abort button
//   sw       : switch bank, sw[3:0] is the opcode source
//   ld_a/ld_b/ld_f : one-cycle register enables (mutually exclusive)
//   op       : registered opcode       step  : current state code
//   busy     : high while in S_EXEC
//
//   state  | meaning
//   S_A    | waiting for press, then load operand A
//   S_B    | waiting for press, then load operand B
//   S_OP   | waiting for press, then capture opcode from sw[3:0]
//   S_EXEC | ALU settling, presses ignored, wait counter running
//   S_SHOW | result strobed, next press returns to S_A
// -----------------------------------------------------------------------------
module alu_step_ctrl
  import alu_step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 1000000,
  parameter int EXEC_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_step,
  input  logic              btn_clr,
  input  logic [31:0]       sw,
  output logic              ld_a,
  output logic              ld_b,
  output logic              ld_f,
  output logic [OP_W-1:0]   op,
  output logic [STEP_W-1:0] step,
  output logic              busy
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(EXEC_WAIT - 1);

  logic              step_p;
  logic              clr_p;
  step_e             state_q;
  step_e             state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              ld_a_d;
  logic              ld_b_d;
  logic              ld_f_d;
  logic              busy_d;
  logic [OP_W-1:0]   op_d;
  logic              unused_sw;

  assign unused_sw = ^sw[31:OP_W];

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_step),
    .press (step_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_clr),
    .press (clr_p)
  );

  // State register; outputs are flopped here too so nothing downstream sees
  // a combinational path from the buttons or switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      wait_q  <= '0;
      ld_a    <= 1'b0;
      ld_b    <= 1'b0;
      ld_f    <= 1'b0;
      busy    <= 1'b0;
      op      <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ld_a    <= ld_a_d;
      ld_b    <= ld_b_d;
      ld_f    <= ld_f_d;
      busy    <= busy_d;
      op      <= op_d;
    end
  end

  // Next state and wait counter. Clear has priority over any step press.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (clr_p) begin
      state_d = S_A;
      wait_d  = '0;
    end else begin
      case (state_q)
        S_A:    if (step_p) state_d = S_B;
        S_B:    if (step_p) state_d = S_OP;
        S_OP:   if (step_p) begin
                  state_d = S_EXEC;
                  wait_d  = WAIT_LOAD;
                end
        S_EXEC: if (wait_q == '0) state_d = S_SHOW;
                else              wait_d  = wait_q - 1'b1;
        S_SHOW: if (step_p) state_d = S_A;
        default: state_d = S_A;
      endcase
    end
  end

  // Next values of the registered outputs. Each ld_* is tied to a single
  // source state, which keeps them mutually exclusive.
  always_comb begin
    ld_a_d = !clr_p && step_p && (state_q == S_A);
    ld_b_d = !clr_p && step_p && (state_q == S_B);
    ld_f_d = !clr_p && (state_q == S_EXEC) && (wait_q == '0);
    busy_d = (state_d == S_EXEC);
    op_d   = op;
    if (clr_p)                               op_d = '0;
    else if (step_p && (state_q == S_OP))    op_d = sw[OP_W-1:0];
  end

  assign step = state_q;

endmodule
